// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
// A 14-state FSM sequences fetch, decode and per-class execute/writeback
// steps. Datapath strobes are decoded from the current state, plus a few
// memory-handshake and flag terms. instr_count counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  fcode,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        lez,
    input  logic        neg,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        irwrite,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        regdest,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsource,
    output logic [3:0]  aluop,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ANDIEX = 4'd9,
        S_ANDIWB = 4'd10,
        S_JAL    = 4'd11,
        S_JMORRD = 4'd12,
        S_BALRN  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FC_JMOR  = 6'b100110;
    localparam logic [5:0] FC_BALRN = 6'b010111;

    state_e      state_q, state_d;
    logic [15:0] count_q;

    // zero and lez qualify pcwritecond inside the datapath, not here.
    logic unused_flags;
    assign unused_flags = zero | lez;

    // Next-state, illegal-opcode detection and datapath strobe decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        illegal     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        irwrite     = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        regdest     = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = 4'b0000;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                aluop   = 4'b1000;
                // Reset holds the state at FETCH; keep IR and PC frozen meanwhile.
                irwrite = mem_ready & rst_n;
                pcwrite = mem_ready & rst_n;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = 4'b1000;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (fcode == FC_JMOR)       state_d = S_JMORRD;
                        else if (fcode == FC_BALRN) state_d = S_BALRN;
                        else                        state_d = S_REXEC;
                    end
                    OP_BEQ, OP_BLEZ: state_d = S_BRANCH;
                    OP_ANDI:         state_d = S_ANDIEX;
                    OP_JAL:          state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 4'b1000;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = 4'b0010;
                state_d = S_RWB;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                aluop       = (opcode == OP_BEQ) ? 4'b0001 : 4'b0101;
                state_d     = S_FETCH;
            end
            S_ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 4'b0100;
                state_d = S_ANDIWB;
            end
            S_ANDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JMORRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                // Read data lands in both rd and PC in the completing cycle.
                if (mem_ready) begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b11;
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    regdest  = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_BALRN: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                pcsource = 2'b11;
                pcwrite  = neg;
                state_d  = S_FETCH;
            end
            default: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            if (state_q != S_FETCH && state_d == S_FETCH && !illegal)
                count_q <= count_q + 16'd1;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, fcode;
    logic        mem_ready, zero, lez, neg;
    logic        pcwrite, pcwritecond, irwrite, iord, memread, memwrite;
    logic        memtoreg, regwrite, regdest, alusrca;
    logic [1:0]  alusrcb, pcsource;
    logic [3:0]  aluop, state;
    logic        illegal;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fcode(fcode),
        .mem_ready(mem_ready), .zero(zero), .lez(lez), .neg(neg),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .irwrite(irwrite),
        .iord(iord), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .regdest(regdest),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop(aluop), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {pcwrite,pcwritecond,irwrite,iord,memread,memwrite,memtoreg,regwrite,regdest,alusrca,
    //  alusrcb,pcsource,aluop}
    logic [17:0] ctrl;
    assign ctrl = {pcwrite, pcwritecond, irwrite, iord, memread, memwrite, memtoreg,
                   regwrite, regdest, alusrca, alusrcb, pcsource, aluop};

    localparam logic [17:0] C_FETCH_IDLE = 18'b0000100000_01_00_1000;
    localparam logic [17:0] C_FETCH_RDY  = 18'b1010100000_01_00_1000;
    localparam logic [17:0] C_DECODE     = 18'b0000000000_11_00_1000;
    localparam logic [17:0] C_MEMADR     = 18'b0000000001_10_00_1000;
    localparam logic [17:0] C_MEMRD      = 18'b0001100000_00_00_0000;
    localparam logic [17:0] C_MEMWB      = 18'b0000001100_00_00_0000;
    localparam logic [17:0] C_MEMWR      = 18'b0001010000_00_00_0000;
    localparam logic [17:0] C_REXEC      = 18'b0000000001_00_00_0010;
    localparam logic [17:0] C_RWB        = 18'b0000000110_00_00_0000;
    localparam logic [17:0] C_BEQ        = 18'b0100000001_00_01_0001;
    localparam logic [17:0] C_BLEZ       = 18'b0100000001_00_01_0101;
    localparam logic [17:0] C_ANDIEX     = 18'b0000000001_10_00_0100;
    localparam logic [17:0] C_ANDIWB     = 18'b0000000100_00_00_0000;
    localparam logic [17:0] C_JAL        = 18'b1000000100_00_10_0000;
    localparam logic [17:0] C_JM_RDY     = 18'b1001101110_00_11_0000;
    localparam logic [17:0] C_BALRN_N0   = 18'b0000000110_00_11_0000;
    localparam logic [17:0] C_BALRN_N1   = 18'b1000000110_00_11_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [17:0] c);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    endtask

    // Runs FETCH (memory ready at once) and lands in DECODE.
    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fc);
        opcode    = op;
        fcode     = fc;
        mem_ready = 1'b1;
        #1;
        expect_st({tag, ".fetch"}, 4'd0, C_FETCH_RDY);
        tick();
        expect_st({tag, ".decode"}, 4'd1, C_DECODE);
    endtask

    task automatic run_branch(input string tag, input logic [5:0] op, input logic z,
                              input logic l, input logic [17:0] c, input logic [15:0] cnt);
        zero = z;
        lez  = l;
        fetch_decode(tag, op, 6'd0);
        tick();
        expect_st({tag, ".branch"}, 4'd8, c);
        tick();
        check({tag, ".ret_state"}, 32'(state), 32'd0);
        check({tag, ".count"}, 32'(instr_count), 32'(cnt));
    endtask

    task automatic run_balrn(input string tag, input logic n, input logic [17:0] c,
                             input logic [15:0] cnt);
        neg = n;
        fetch_decode(tag, 6'b000000, 6'b010111);
        tick();
        expect_st({tag, ".balrn"}, 4'd13, c);
        tick();
        check({tag, ".ret_state"}, 32'(state), 32'd0);
        check({tag, ".count"}, 32'(instr_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; fcode = '0;
        zero = 1'b0; lez = 1'b0; neg = 1'b0;

        // Reset: FETCH with memread high, IR/PC writes blocked though mem_ready=1.
        #3;
        expect_st("rst", 4'd0, C_FETCH_IDLE);
        check("rst.count", 32'(instr_count), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #2;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        expect_st("rst.fetch_wait", 4'd0, C_FETCH_IDLE);

        // lw with memory ready at once
        fetch_decode("lw", 6'b100011, 6'd0);
        tick(); expect_st("lw.memadr", 4'd2, C_MEMADR);
        tick(); expect_st("lw.memrd", 4'd3, C_MEMRD);
        tick(); expect_st("lw.memwb", 4'd4, C_MEMWB);
        tick(); expect_st("lw.done", 4'd0, C_FETCH_RDY);
        check("lw.count", 32'(instr_count), 32'd1);

        // sw with three wait cycles in MEMWR
        fetch_decode("sw", 6'b101011, 6'd0);
        tick(); expect_st("sw.memadr", 4'd2, C_MEMADR);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; expect_st("sw.wait", 4'd5, C_MEMWR);
            tick();
        end
        mem_ready = 1'b1;
        #1; expect_st("sw.ready", 4'd5, C_MEMWR);
        tick();
        check("sw.ret_state", 32'(state), 32'd0);
        check("sw.count", 32'(instr_count), 32'd2);

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0;
        #1; expect_st("fetch.stall", 4'd0, C_FETCH_IDLE);
        tick();
        check("fetch.stall_hold", 32'(state), 32'd0);

        run_branch("beq_z0",  6'b000100, 1'b0, 1'b0, C_BEQ,  16'd3);
        run_branch("beq_z1",  6'b000100, 1'b1, 1'b0, C_BEQ,  16'd4);
        run_branch("blez_l0", 6'b000110, 1'b0, 1'b0, C_BLEZ, 16'd5);
        run_branch("blez_l1", 6'b000110, 1'b0, 1'b1, C_BLEZ, 16'd6);

        // Illegal opcode: one-cycle pulse in DECODE, count unchanged
        fetch_decode("ill", 6'b111111, 6'd0);
        check("ill.pulse", 32'(illegal), 32'd1);
        tick();
        check("ill.ret_state", 32'(state), 32'd0);
        check("ill.pulse_end", 32'(illegal), 32'd0);
        check("ill.count", 32'(instr_count), 32'd6);

        // R-type add
        fetch_decode("rtype", 6'b000000, 6'b100000);
        tick(); expect_st("rtype.exec", 4'd6, C_REXEC);
        tick(); expect_st("rtype.wb", 4'd7, C_RWB);
        tick(); check("rtype.count", 32'(instr_count), 32'd7);

        // andi
        fetch_decode("andi", 6'b001100, 6'd0);
        tick(); expect_st("andi.exec", 4'd9, C_ANDIEX);
        tick(); expect_st("andi.wb", 4'd10, C_ANDIWB);
        tick(); check("andi.count", 32'(instr_count), 32'd8);

        // jal
        fetch_decode("jal", 6'b000011, 6'd0);
        tick(); expect_st("jal.exec", 4'd11, C_JAL);
        tick(); check("jal.count", 32'(instr_count), 32'd9);

        // jmor: read stalls one cycle, then PC and rd load together
        fetch_decode("jmor", 6'b000000, 6'b100110);
        tick();
        mem_ready = 1'b0;
        #1; expect_st("jmor.wait", 4'd12, C_MEMRD);
        tick();
        check("jmor.hold", 32'(state), 32'd12);
        mem_ready = 1'b1;
        #1; expect_st("jmor.ready", 4'd12, C_JM_RDY);
        tick();
        check("jmor.ret_state", 32'(state), 32'd0);
        check("jmor.count", 32'(instr_count), 32'd10);

        run_balrn("balrn_n0", 1'b0, C_BALRN_N0, 16'd11);
        run_balrn("balrn_n1", 1'b1, C_BALRN_N1, 16'd12);

        // Asynchronous reset in the middle of a MEMRD wait
        fetch_decode("rst_mid", 6'b100011, 6'd0);
        tick();
        tick();
        mem_ready = 1'b0;
        #1; check("rst_mid.in_memrd", 32'(state), 32'd3);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        expect_st("rst_mid.async", 4'd0, C_FETCH_IDLE);
        check("rst_mid.count", 32'(instr_count), 32'd0);
        check("rst_mid.regwrite", 32'(regwrite), 32'd0);
        tick();
        check("rst_mid.held", 32'(state), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_mid.first_fetch", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction register bits [31:26], valid from DECODE onward.
REQ-004 SHALL have port fcode, input, 6 bits: instruction register bits [5:0].
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write in this cycle.
REQ-006 SHALL have ports zero, lez and neg, input, 1 bit each: ALU flags (result==0, rs<=0, rs<0).
REQ-007 SHALL have ports pcwrite, pcwritecond, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdest and alusrca, output, 1 bit each: datapath strobes and selects.
REQ-008 SHALL have ports alusrcb and pcsource, output, 2 bits each; ALU B select (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2); PC select (00 ALU, 01 ALUOut, 10 jump target, 11 reg/MDR).
REQ-009 SHALL have port aluop, output, 4 bits: {aluop3,aluop2,aluop1,aluop0}.
REQ-010 SHALL have ports state (output, 4 bits, current state), illegal (output, 1 bit, one-cycle pulse) and instr_count (output, 16 bits, retired instructions).

Function
REQ-011 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, ANDIEX=9, ANDIWB=10, JAL=11, JMORRD=12, BALRN=13; codes 14-15 SHALL go to FETCH with illegal=1.
REQ-012 SHALL drive every output not listed for a state as 0.
REQ-013 FETCH SHALL assert memread=1, iord=0, alusrca=0, alusrcb=01, aluop=1000 and pcsource=00; irwrite and pcwrite SHALL equal mem_ready; the state SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE SHALL drive alusrcb=11 and aluop=1000 (branch target into ALUOut).
REQ-015 DECODE SHALL dispatch by opcode: 100011 or 101011 -> MEMADR; 000000 -> REXEC, except fcode 100110 -> JMORRD and 010111 -> BALRN; 000100 or 000110 -> BRANCH; 001100 -> ANDIEX; 000011 -> JAL.
REQ-016 DECODE SHALL, for any other opcode, pulse illegal=1 and go to FETCH without incrementing instr_count.
REQ-017 MEMADR SHALL assert alusrca=1, alusrcb=10 and aluop=1000, then go to MEMRD for opcode 100011 or MEMWR otherwise.
REQ-018 MEMRD SHALL assert memread=1 and iord=1, holding until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB SHALL assert regwrite=1 and memtoreg=1, then go to FETCH.
REQ-020 MEMWR SHALL assert memwrite=1 and iord=1, holding until mem_ready=1, then go to FETCH.
REQ-021 REXEC SHALL assert alusrca=1, alusrcb=00 and aluop=0010; RWB SHALL assert regwrite=1 and regdest=1; sll SHALL follow this same path.
REQ-022 BRANCH SHALL assert alusrca=1, pcwritecond=1 and pcsource=01, with aluop=0001 for beq (PC loads when zero=1) and aluop=0101 for blez (PC loads when lez=1).
REQ-023 ANDIEX SHALL assert alusrca=1, alusrcb=10 and aluop=0100; ANDIWB SHALL assert regwrite=1 and regdest=0.
REQ-024 JAL SHALL assert pcwrite=1, pcsource=10 and regwrite=1 (link register $31 is forced by the datapath), then go to FETCH.
REQ-025 JMORRD SHALL assert memread=1 and iord=1 (address = rs), holding until mem_ready=1.
REQ-026 In the mem_ready=1 cycle, JMORRD SHALL assert pcwrite=1, pcsource=11, memtoreg=1, regwrite=1 and regdest=1, then go to FETCH.
REQ-027 BALRN SHALL assert regwrite=1, regdest=1, pcsource=11 and pcwrite=neg, then go to FETCH.
REQ-028 instr_count SHALL increment by 1 on every transition into FETCH from any non-FETCH state except the illegal path, wrapping 16'hFFFF -> 0.
REQ-029 Wait states SHALL tolerate unbounded mem_ready=0 with all outputs stable.
REQ-030 mem_ready SHALL be ignored outside FETCH, MEMRD, MEMWR and JMORRD.

Reset
REQ-031 rst_n=0 SHALL immediately force state=FETCH, instr_count=0 and illegal=0, regardless of clk, and SHALL abort any in-flight access.
REQ-032 While rst_n=0, irwrite and pcwrite SHALL be 0 and memread SHALL be 1.
REQ-033 After rst_n deasserts, the first fetch SHALL begin on the next rising clk.

Verification
REQ-034 lw (100011), mem_ready=1 immediately -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite in MEMWB; instr_count=1.
REQ-035 sw with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles, no regwrite, then FETCH.
REQ-036 beq with zero=0 and then zero=1 -> pcwritecond=1 and pcsource=01 in both runs; PC loads only when zero=1; blez SHALL be repeated with lez.
REQ-037 opcode 111111 -> illegal pulses for 1 cycle in DECODE, next state FETCH, instr_count unchanged.
REQ-038 R-type, fcode 100110 -> JMORRD, pcwrite, regwrite and memtoreg all high in the mem_ready cycle; fcode 010111 with neg=0 -> pcwrite=0 and regwrite=1.
REQ-039 rst_n low mid-MEMRD -> state=0 without a clock edge; instr_count=0; no regwrite issued.
